// File: rtl/ni.sv
// Network interface: core writes queue into a TX FIFO and leave as 64-bit flits, and router flits queue into an RX FIFO that core reads drain.
// Optional macro NI_LOOPBACK_EN turns TX flits addressed to LOCAL_ID back into the RX FIFO instead of sending them to the network.
module ni #(
   parameter int          FIFO_DEPTH = 4,
   parameter logic [7:0]  LOCAL_ID   = 8'h00
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] core_write_data,
   input  logic [31:0] core_write_addr,
   input  logic        core_write_en,
   input  logic        core_read_en,
   output logic [31:0] core_read_data,
   output logic        tx_full,
   output logic        rx_empty,
   output logic [63:0] net_tx_flit,
   output logic        net_tx_valid,
   input  logic        net_tx_ready,
   input  logic [63:0] net_rx_flit,
   input  logic        net_rx_valid,
   output logic        net_rx_ready
);

   localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

   // TX FIFO state
   logic [63:0]      tx_mem [FIFO_DEPTH];
   logic [PTR_W-1:0] tx_wr_ptr, tx_rd_ptr;
   logic [CNT_W-1:0] tx_count;
   logic [63:0]      tx_head;
   logic             tx_empty, tx_push, tx_pop;

   // RX FIFO state (only the data half of a flit is ever returned to the core)
   logic [31:0]      rx_mem [FIFO_DEPTH];
   logic [PTR_W-1:0] rx_wr_ptr, rx_rd_ptr;
   logic [CNT_W-1:0] rx_count;
   logic             rx_full, rx_push, rx_pop, net_rx_push;
   logic [31:0]      rx_push_data;

   logic             head_local, loop_move;
   logic             unused_rx_addr;

   assign tx_full  = (tx_count == FULL_CNT);
   assign tx_empty = (tx_count == '0);
   assign tx_head  = tx_mem[tx_rd_ptr];
   assign tx_push  = core_write_en && !tx_full;

   assign rx_full      = (rx_count == FULL_CNT);
   assign rx_empty     = (rx_count == '0);
   assign net_rx_ready = !rx_full;
   assign net_rx_push  = net_rx_valid && !rx_full;
   assign rx_pop       = core_read_en && !rx_empty;
   assign unused_rx_addr = ^net_rx_flit[63:32];

`ifdef NI_LOOPBACK_EN
   // Network RX wins the RX write port; a local head simply waits a cycle.
   assign head_local = !tx_empty && (tx_head[63:56] == LOCAL_ID);
   assign loop_move  = head_local && !rx_full && !net_rx_push;
`else
   logic unused_local_id;
   assign head_local      = 1'b0;
   assign loop_move       = 1'b0;
   assign unused_local_id = ^LOCAL_ID;
`endif

   assign net_tx_flit  = tx_head;
   assign net_tx_valid = !tx_empty && !head_local;
   assign tx_pop       = (net_tx_valid && net_tx_ready) || loop_move;

   assign rx_push      = net_rx_push || loop_move;
   assign rx_push_data = net_rx_push ? net_rx_flit[31:0] : tx_head[31:0];

   // NOTE: storage arrays are left out of reset; the counts alone decide which entries are valid.
   always_ff @(posedge clk) begin
      if (tx_push) tx_mem[tx_wr_ptr] <= {core_write_addr, core_write_data};
      if (rx_push) rx_mem[rx_wr_ptr] <= rx_push_data;
   end

   // NOTE: all state registers use non-blocking assignment so every update sees pre-edge values.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         tx_wr_ptr <= '0;
         tx_rd_ptr <= '0;
         tx_count  <= '0;
      end else begin
         if (tx_push) tx_wr_ptr <= tx_wr_ptr + PTR_W'(1);
         if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + PTR_W'(1);
         case ({tx_push, tx_pop})
            2'b10:   tx_count <= tx_count + CNT_W'(1);
            2'b01:   tx_count <= tx_count - CNT_W'(1);
            default: tx_count <= tx_count;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rx_wr_ptr      <= '0;
         rx_rd_ptr      <= '0;
         rx_count       <= '0;
         core_read_data <= '0;
      end else begin
         if (rx_push) rx_wr_ptr <= rx_wr_ptr + PTR_W'(1);
         if (rx_pop) begin
            rx_rd_ptr      <= rx_rd_ptr + PTR_W'(1);
            core_read_data <= rx_mem[rx_rd_ptr];
         end
         case ({rx_push, rx_pop})
            2'b10:   rx_count <= rx_count + CNT_W'(1);
            2'b01:   rx_count <= rx_count - CNT_W'(1);
            default: rx_count <= rx_count;
         endcase
      end
   end

endmodule

// File: tb/tb_ni.sv
// Directed bench for ni: reset, TX path, RX path, full/empty limits and simultaneous push+pop.
// Defining NI_LOOPBACK_EN adds the loopback scenario with LOCAL_ID = 8'hA5.
module tb_ni;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] core_write_data, core_write_addr;
   logic        core_write_en, core_read_en;
   logic [31:0] core_read_data;
   logic        tx_full, rx_empty;
   logic [63:0] net_tx_flit;
   logic        net_tx_valid, net_tx_ready;
   logic [63:0] net_rx_flit;
   logic        net_rx_valid, net_rx_ready;

   int n_cmp = 0;
   int n_mis = 0;

`ifdef NI_LOOPBACK_EN
   localparam logic [31:0] TX_ADDR = 32'h5A5A5A5A;
`else
   localparam logic [31:0] TX_ADDR = 32'hA5A5A5A5;
`endif

   ni #(.FIFO_DEPTH(4), .LOCAL_ID(8'hA5)) dut (
      .clk(clk), .reset(reset),
      .core_write_data(core_write_data), .core_write_addr(core_write_addr),
      .core_write_en(core_write_en), .core_read_en(core_read_en),
      .core_read_data(core_read_data), .tx_full(tx_full), .rx_empty(rx_empty),
      .net_tx_flit(net_tx_flit), .net_tx_valid(net_tx_valid), .net_tx_ready(net_tx_ready),
      .net_rx_flit(net_rx_flit), .net_rx_valid(net_rx_valid), .net_rx_ready(net_rx_ready)
   );

   always #5 clk = ~clk;

   // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      core_write_data = '0; core_write_addr = '0; core_write_en = 1'b0;
      core_read_en = 1'b0; net_tx_ready = 1'b0; net_rx_flit = '0; net_rx_valid = 1'b0;
      #20;
      n_cmp++; if (core_read_data !== 32'h0) begin n_mis++; $display("FAIL reset_read_data: got %h want 0", core_read_data); end
      n_cmp++; if (rx_empty !== 1'b1) begin n_mis++; $display("FAIL reset_rx_empty: got %b want 1", rx_empty); end
      n_cmp++; if (net_tx_valid !== 1'b0) begin n_mis++; $display("FAIL reset_tx_valid: got %b want 0", net_tx_valid); end
      n_cmp++; if (tx_full !== 1'b0) begin n_mis++; $display("FAIL reset_tx_full: got %b want 0", tx_full); end
      n_cmp++; if (net_rx_ready !== 1'b1) begin n_mis++; $display("FAIL reset_rx_ready: got %b want 1", net_rx_ready); end
      @(negedge clk);
      reset = 1'b1;
      tick();
   endtask

   task automatic test_tx_basic();
      core_write_addr = TX_ADDR; core_write_data = 32'hAAAAAAAA; core_write_en = 1'b1;
      net_tx_ready = 1'b0;
      tick();
      core_write_en = 1'b0;
      n_cmp++; if (net_tx_valid !== 1'b1) begin n_mis++; $display("FAIL tx_valid_after_write: got %b want 1", net_tx_valid); end
      n_cmp++; if (net_tx_flit !== {TX_ADDR, 32'hAAAAAAAA}) begin n_mis++; $display("FAIL tx_flit: got %h want %h", net_tx_flit, {TX_ADDR, 32'hAAAAAAAA}); end
      tick();
      n_cmp++; if (net_tx_flit !== {TX_ADDR, 32'hAAAAAAAA} || net_tx_valid !== 1'b1) begin n_mis++; $display("FAIL tx_flit_stable: got %h/%b want %h/1", net_tx_flit, net_tx_valid, {TX_ADDR, 32'hAAAAAAAA}); end
      net_tx_ready = 1'b1;
      tick();
      net_tx_ready = 1'b0;
      n_cmp++; if (net_tx_valid !== 1'b0) begin n_mis++; $display("FAIL tx_valid_after_accept: got %b want 0", net_tx_valid); end
   endtask

   task automatic test_read_empty();
      core_read_en = 1'b1;
      tick();
      core_read_en = 1'b0;
      n_cmp++; if (core_read_data !== 32'h0) begin n_mis++; $display("FAIL read_empty_data: got %h want 0", core_read_data); end
      n_cmp++; if (rx_empty !== 1'b1) begin n_mis++; $display("FAIL read_empty_flag: got %b want 1", rx_empty); end
   endtask

   task automatic test_rx_fill_drain();
      for (int i = 1; i <= 4; i++) begin
         n_cmp++; if (net_rx_ready !== 1'b1) begin n_mis++; $display("FAIL rx_ready_before_%0d: got %b want 1", i, net_rx_ready); end
         net_rx_valid = 1'b1; net_rx_flit = {32'h0100_0000, 32'(i)};
         tick();
      end
      net_rx_valid = 1'b0;
      n_cmp++; if (net_rx_ready !== 1'b0) begin n_mis++; $display("FAIL rx_ready_full: got %b want 0", net_rx_ready); end
      n_cmp++; if (rx_empty !== 1'b0) begin n_mis++; $display("FAIL rx_empty_full: got %b want 0", rx_empty); end
      core_read_en = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         tick();
         n_cmp++; if (core_read_data !== 32'(i)) begin n_mis++; $display("FAIL rx_read_%0d: got %h want %h", i, core_read_data, 32'(i)); end
      end
      core_read_en = 1'b0;
      n_cmp++; if (rx_empty !== 1'b1) begin n_mis++; $display("FAIL rx_empty_after_drain: got %b want 1", rx_empty); end
      n_cmp++; if (net_rx_ready !== 1'b1) begin n_mis++; $display("FAIL rx_ready_after_drain: got %b want 1", net_rx_ready); end
   endtask

   task automatic test_tx_full();
      net_tx_ready = 1'b0;
      for (int i = 1; i <= 5; i++) begin
         core_write_addr = 32'h0200_0000 + 32'(i); core_write_data = 32'h1000 + 32'(i); core_write_en = 1'b1;
         tick();
         if (i == 3) begin
            n_cmp++; if (tx_full !== 1'b0) begin n_mis++; $display("FAIL tx_full_after_3: got %b want 0", tx_full); end
         end
         if (i >= 4) begin
            n_cmp++; if (tx_full !== 1'b1) begin n_mis++; $display("FAIL tx_full_after_%0d: got %b want 1", i, tx_full); end
         end
      end
      core_write_en = 1'b0;
      net_tx_ready = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         n_cmp++;
         if (net_tx_valid !== 1'b1 || net_tx_flit !== {32'h0200_0000 + 32'(i), 32'h1000 + 32'(i)}) begin
            n_mis++; $display("FAIL tx_drain_%0d: got %h/%b want %h/1", i, net_tx_flit, net_tx_valid, {32'h0200_0000 + 32'(i), 32'h1000 + 32'(i)});
         end
         tick();
         n_cmp++; if (tx_full !== 1'b0) begin n_mis++; $display("FAIL tx_not_full_drain_%0d: got %b want 0", i, tx_full); end
      end
      net_tx_ready = 1'b0;
      n_cmp++; if (net_tx_valid !== 1'b0) begin n_mis++; $display("FAIL tx_dropped_fifth: got valid %b want 0", net_tx_valid); end
   endtask

   task automatic test_back_to_back();
      // TX: push and pop in the same cycle keep exactly one flit in flight.
      net_tx_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         core_write_addr = 32'h0300_0000; core_write_data = 32'h10 + 32'(i); core_write_en = 1'b1;
         tick();
         n_cmp++; if (net_tx_valid !== 1'b1 || net_tx_flit !== {32'h0300_0000, 32'h10 + 32'(i)}) begin
            n_mis++; $display("FAIL b2b_tx_%0d: got %h/%b want %h/1", i, net_tx_flit, net_tx_valid, {32'h0300_0000, 32'h10 + 32'(i)});
         end
      end
      core_write_en = 1'b0;
      tick();
      net_tx_ready = 1'b0;
      n_cmp++; if (net_tx_valid !== 1'b0) begin n_mis++; $display("FAIL b2b_tx_end: got %b want 0", net_tx_valid); end
      // RX: network push concurrent with core pop.
      net_rx_valid = 1'b1; net_rx_flit = {32'h0, 32'h21};
      tick();
      net_rx_flit = {32'h0, 32'h22}; core_read_en = 1'b1;
      tick();
      net_rx_valid = 1'b0;
      n_cmp++; if (core_read_data !== 32'h21 || rx_empty !== 1'b0) begin n_mis++; $display("FAIL b2b_rx_first: got %h/%b want 21/0", core_read_data, rx_empty); end
      tick();
      core_read_en = 1'b0;
      n_cmp++; if (core_read_data !== 32'h22 || rx_empty !== 1'b1) begin n_mis++; $display("FAIL b2b_rx_second: got %h/%b want 22/1", core_read_data, rx_empty); end
   endtask

`ifdef NI_LOOPBACK_EN
   task automatic test_loopback();
      core_write_addr = 32'hA500_0000; core_write_data = 32'h12345678; core_write_en = 1'b1;
      net_tx_ready = 1'b1;
      tick();
      core_write_en = 1'b0;
      n_cmp++; if (net_tx_valid !== 1'b0) begin n_mis++; $display("FAIL loop_tx_valid: got %b want 0", net_tx_valid); end
      tick();
      n_cmp++; if (net_tx_valid !== 1'b0) begin n_mis++; $display("FAIL loop_tx_valid_after: got %b want 0", net_tx_valid); end
      n_cmp++; if (rx_empty !== 1'b0) begin n_mis++; $display("FAIL loop_rx_empty: got %b want 0", rx_empty); end
      core_read_en = 1'b1;
      tick();
      core_read_en = 1'b0; net_tx_ready = 1'b0;
      n_cmp++; if (core_read_data !== 32'h12345678) begin n_mis++; $display("FAIL loop_read: got %h want 12345678", core_read_data); end
   endtask
`endif

   initial begin
      test_reset();
      test_tx_basic();
      test_read_empty();
      test_rx_fill_drain();
      test_tx_full();
      test_back_to_back();
`ifdef NI_LOOPBACK_EN
      test_loopback();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: simulation exceeded 100us");
      $fatal(1, "timeout");
   end

endmodule
